// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W            = 8;
  localparam int unsigned DATA_W            = 8;
  localparam int unsigned CNT_W             = 4;
  localparam int unsigned MAX_BURST_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Request presented to the external RAM in the current cycle.
  typedef struct packed {
    logic [ADDR_W-1:0] adrs;
    logic [DATA_W-1:0] data;
    logic              wr_en;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM signals of the memory arbiter, bundled as one interface.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic [ADDR_W-1:0] mem_adrs;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_q;

  // Environment side: requesters plus the RAM.
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_adrs, mem_data, mem_wr_en
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_q,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_adrs, mem_data, mem_wr_en
  );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single-port 256x8 RAM with bounded bursts
// and last-owner tie breaking; reads return one cycle after the beat.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_e       state_q;
  arb_state_e       state_nxt;
  logic             last_owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc_c;
  logic             beat0_c;
  logic             beat1_c;
  mem_req_t         mem_req_c;

  // Beat count after the current beat, held at MAX_BURST once reached.
  assign cnt_inc_c = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    beat0_c   = 1'b0;
    beat1_c   = 1'b0;
    mem_req_c = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_nxt = last_owner_q ? ST_OWN0 : ST_OWN1;
        end else if (bus.req0) begin
          state_nxt = ST_OWN0;
        end else if (bus.req1) begin
          state_nxt = ST_OWN1;
        end
      end

      ST_OWN0: begin
        mem_req_c.adrs  = bus.addr0;
        mem_req_c.data  = bus.wdata0;
        mem_req_c.wr_en = bus.we0 & bus.req0;
        if (!bus.req0) begin
          state_nxt = bus.req1 ? ST_OWN1 : ST_IDLE;
        end else begin
          beat0_c = 1'b1;
          cnt_nxt = cnt_inc_c;
          if ((cnt_inc_c == MAX_CNT) && bus.req1) begin
            state_nxt = ST_OWN1;
          end
        end
      end

      ST_OWN1: begin
        mem_req_c.adrs  = bus.addr1;
        mem_req_c.data  = bus.wdata1;
        mem_req_c.wr_en = bus.we1 & bus.req1;
        if (!bus.req1) begin
          state_nxt = bus.req0 ? ST_OWN0 : ST_IDLE;
        end else begin
          beat1_c = 1'b1;
          cnt_nxt = cnt_inc_c;
          if ((cnt_inc_c == MAX_CNT) && bus.req0) begin
            state_nxt = ST_OWN0;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Every new tenure starts counting from zero.
    if (state_nxt != state_q) begin
      cnt_nxt = '0;
    end

    // Synchronous reset must keep writes away from the RAM in the reset cycle.
    if (reset) begin
      mem_req_c = '0;
    end
  end

  assign bus.mem_adrs  = mem_req_c.adrs;
  assign bus.mem_data  = mem_req_c.data;
  assign bus.mem_wr_en = mem_req_c.wr_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      bus.gnt0     <= 1'b0;
      bus.gnt1     <= 1'b0;
      bus.rvalid0  <= 1'b0;
      bus.rvalid1  <= 1'b0;
      bus.rdata0   <= '0;
      bus.rdata1   <= '0;
    end else begin
      state_q     <= state_nxt;
      cnt_q       <= cnt_nxt;
      bus.gnt0    <= (state_nxt == ST_OWN0);
      bus.gnt1    <= (state_nxt == ST_OWN1);
      bus.rvalid0 <= beat0_c & ~bus.we0;
      bus.rvalid1 <= beat1_c & ~bus.we1;
      if (state_nxt == ST_OWN0) begin
        last_owner_q <= 1'b0;
      end else if (state_nxt == ST_OWN1) begin
        last_owner_q <= 1'b1;
      end
      if (beat0_c && !bus.we0) begin
        bus.rdata0 <= bus.mem_q;
      end
      if (beat1_c && !bus.we1) begin
        bus.rdata1 <= bus.mem_q;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MAX_BURST, 4, maximum consecutive transfers per tenure while the other requester waits; legal range 1..15.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0 / req1  input  1  requester k asks for the memory; held high for as long as it has accesses pending.
REQ-005 we0 / we1  input  1  the current access of requester k is a write (1) or a read (0).
REQ-006 addr0 / addr1  input  8  access address of requester k.
REQ-007 wdata0 / wdata1  input  8  write data of requester k.
REQ-008 gnt0 / gnt1  output  1  registered ownership flag; at most one is high in any cycle.
REQ-009 rvalid0 / rvalid1  output  1  one-cycle pulse; rdata_k is valid.
REQ-010 rdata0 / rdata1  output  8  registered read data for requester k.
REQ-011 mem_adrs  output  8  address to the 256x8 RAM.
REQ-012 mem_data  output  8  write data to the RAM.
REQ-013 mem_wr_en  output  1  RAM write enable.
REQ-014 mem_q  input  8  RAM read data; combinational from mem_adrs.

Function
REQ-015 States SHALL be IDLE, OWN0 and OWN1, held in a register; gnt_k SHALL be high exactly when state is OWN_k.
REQ-016 A transfer for requester k SHALL occur in any cycle where gnt_k=1 and req_k=1; each such cycle is one beat.
REQ-017 In OWN_k, mem_adrs, mem_data and mem_wr_en SHALL equal addr_k, wdata_k and (we_k & req_k), combinationally; in IDLE, all three SHALL be 0.
REQ-018 On a read beat (we_k=0), rdata_k SHALL capture mem_q at the closing edge, and rvalid_k SHALL be high for exactly the next cycle (1-cycle read latency).
REQ-019 A write beat SHALL raise no rvalid; the RAM updates at the closing edge.
REQ-020 A read of an address written in the same cycle cannot occur, because only one beat occurs per cycle.
REQ-021 A read issued in the cycle after a write to the same address SHALL return the new data.
REQ-022 IDLE transitions: req0 only -> OWN0; req1 only -> OWN1; both -> OWN of the requester that is not last_owner; neither -> IDLE.
REQ-023 The IDLE state SHALL perform no transfer.
REQ-024 last_owner SHALL be a 1-bit register, updated to k on every entry into OWN_k; its reset value is 1, so requester 0 wins the first tie.
REQ-025 beat_cnt SHALL be a 4-bit register that clears on entry into any OWN state and increments on each beat, saturating at MAX_BURST.
REQ-026 In OWN_k with req_k=0, the next state SHALL be OWN_other if req_other=1, else IDLE; the cycle SHALL carry no transfer.
REQ-027 In OWN_k with req_k=1, the next state SHALL be OWN_other when this beat makes beat_cnt reach MAX_BURST and req_other=1; otherwise the state SHALL remain OWN_k.
REQ-028 The handoff in REQ-027 SHALL have no idle cycle between tenures.
REQ-029 With the other requester idle, the owner SHALL keep the grant indefinitely; beat_cnt saturates, and a later req_other forces a handoff after the owner's next beat.
REQ-030 Requesters SHALL treat gnt as advisory.
REQ-031 A requester's addr, we and wdata are consumed only in beat cycles; changing them every cycle SHALL be legal.
REQ-032 A requester waits no more than MAX_BURST+1 cycles from req rising to its first beat while the other is active.

Reset
REQ-033 While reset=1 at an edge: state <= IDLE, last_owner <= 1, beat_cnt <= 0, gnt0/gnt1 <= 0, rvalid0/rvalid1 <= 0, rdata0/rdata1 <= 0.
REQ-034 While in reset, mem_wr_en SHALL be 0, so no write reaches the RAM.
REQ-035 A reset asserted mid-tenure SHALL abort the tenure; the pending rvalid for a read beat in the reset cycle SHALL be dropped.

Structure
REQ-036 The state encoding (IDLE/OWN0/OWN1) and the MAX_BURST default SHALL live in the shared package mem_arb_pkg.
REQ-037 The design SHALL be a single module with no sub-module; the RAM stays external and connects through the mem_* ports.

Verification
REQ-038 Single read: RAM[0x07]=0x03, req0=1, we0=0, addr0=0x07 -> gnt0 rises next cycle; in the cycle after the beat, rvalid0=1 and rdata0=0x03.
REQ-039 Write then read: requester 1 writes 0xA5 to 0x09, then reads 0x09 on the next beat -> rdata1=0xA5 one cycle after the read beat.
REQ-040 Tie and fairness: req0 and req1 rise together after reset, MAX_BURST=4 -> OWN0 for 4 beats, OWN1 for 4 beats, then OWN0; gnt0 and gnt1 are never both high; no idle cycle at handoffs.
REQ-041 Release: in OWN0, req0 falls while req1=0 -> IDLE next cycle with mem_wr_en=0.
REQ-042 Release with waiter: in OWN0, req0 falls while req1=1 -> OWN1 next cycle.
REQ-043 Saturated owner: req1 alone for 20 beats, then req0 rises -> OWN0 follows requester 1's next beat.
REQ-044 Reset mid-burst: assert reset during an OWN1 write burst -> all outputs 0 next cycle, no further RAM writes, and requester 0 wins the next tie.
